buffer_issuer: RTL and testbench
================================

Name: buffer_issuer

Overview:
Initiator side of the single-cycle `do`/`done` capture handshake used by the matrix multiplier's operand and result buffers. It captures a block of up to DEPTH words in parallel on `start`. It then issues the words one at a time to a downstream capture buffer, asserting `do` with the word on `d_out` and waiting for that buffer's `done` before advancing. It sits between the row/column operand staging logic and the per-lane buffers feeding the 32x32 Vedic multipliers.

Parameters:
- N, 32, word width in bits.
- DEPTH, 4, maximum words per burst.
- TIMEOUT, 8, cycles to wait for `done` after a `do` before aborting (TIMEOUT >= 2).
- CW, $clog2(DEPTH+1), width of the count and progress fields (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, single-cycle request to begin a burst; sampled only in IDLE.
- load_data, input, DEPTH*N, burst words; word i = load_data[i*N +: N]; captured on accepted start.
- count, input, CW, number of words to send; captured on accepted start.
- done_in, input, 1, acknowledge from the downstream buffer's `done`.
- d_out, output, N, word being issued.
- do, output, 1, single-cycle capture strobe to the downstream buffer.
- busy, output, 1, high from the cycle after an accepted start until FINISH is left.
- finished, output, 1, single-cycle pulse at end of burst (normal or aborted).
- timeout_err, output, 1, sticky abort flag; cleared on next accepted start.
- sent_cnt, output, CW, words acknowledged in current/last burst.

Behaviour:
- Reset (asynchronous assert while reset=0): state=IDLE; d_out=0, do=0, busy=0, finished=0, timeout_err=0, sent_cnt=0, internal data/count/timer registers=0. Deassertion is synchronous to clk.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE: on start=1:
  - capture load_data and count; clamp count to DEPTH if greater.
  - clear sent_cnt and timeout_err.
  - next state = FINISH if the clamped count is 0, else ISSUE.
- start outside IDLE is ignored. load_data and count are don't-care after capture.
- ISSUE (one cycle):
  - register d_out = word[sent_cnt] and do=1, so both are visible in the same cycle.
  - clear the timer; go to WAIT.
  - do is never high for more than one cycle.
- WAIT: do=0 and d_out held.
  - If done_in=1: sent_cnt+1. If sent_cnt+1 == count, go to FINISH; otherwise go to ISSUE.
  - Else the timer increments. When the timer reaches TIMEOUT-1 with no done_in: set timeout_err=1 and go to FINISH without incrementing sent_cnt.
  - done_in and timer expiry in the same cycle: done_in wins.
- FINISH (one cycle): finished=1, busy=0 on exit, then return to IDLE.
- done_in while in IDLE, ISSUE or FINISH is ignored and has no effect on sent_cnt.
- Timing with an immediately acking buffer (done_in one cycle after do):
  - start accepted in cycle 0; do in cycle 1; done_in in cycle 2; next do in cycle 3.
  - Throughput is 1 word per 2 cycles.
  - For K words, finished pulses in cycle 2K+1.
- count=0: finished pulses in cycle 1, do never asserts, sent_cnt=0.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. No partial finished pulse.
- Word index never exceeds count-1; there is no wrap-around.
- Arithmetic: sent_cnt and the timer are unsigned, and the timer width is $clog2(TIMEOUT).

Decomposition:
- Shared package matrix_mul_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_FINISH=2'd3.
  - default N=32.
- No sub-module is needed. The word-select mux is inline (indexed part-select). Synthesizable in a single module of about 150-200 lines.

Test Plan:
- Normal burst: DEPTH=4, count=3, words 0x11111111/0x22222222/0x33333333, bench buffer acks 1 cycle after do → do pulses in cycles 1, 3, 5 carrying those words in order. finished in cycle 7, sent_cnt=3, timeout_err=0.
- count=0 and count=7 (clamped): count=0 → finished in cycle 1 with no do. count=7 → exactly 4 do pulses and sent_cnt=4.
- Timeout: TIMEOUT=8, the 2nd word is never acked → finished 8 cycles after the 2nd do, timeout_err=1, sent_cnt=1. The next start clears timeout_err.
- Late ack and spurious ack: ack delayed 5 cycles → no timeout and the word is held on d_out. done_in pulsed in IDLE → sent_cnt is unchanged.
- Collision: done_in arrives on the expiry cycle → the word counts, timeout_err=0. start asserted while busy → ignored, the burst completes unchanged.
- Reset mid-burst: reset=0 asserted during WAIT with no clock edge → outputs are 0 immediately. After release, a fresh start with count=2 sends words 0 and 1.

Source files
------------

// File: rtl/matrix_mul_pkg.sv
// matrix_mul_pkg
//   Shared definitions for the matrix multiplier buffer handshake blocks.
//   Holds the default word width and the issuer state encoding.
//   No ports (package).
package matrix_mul_pkg;

    localparam int DEFAULT_N = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/buffer_issuer_if.sv
// buffer_issuer_if
//   Bundles the request side (start/load_data/count), the downstream
//   do/done capture handshake and the status outputs of buffer_issuer.
//   The capture strobe is named do_strobe because "do" is a reserved word.
//   Signals:
//     start       - single-cycle burst request
//     load_data   - DEPTH packed words, word i at [i*N +: N]
//     count       - words to send in the burst
//     done_in     - acknowledge from the downstream buffer
//     d_out       - word being issued
//     do_strobe   - single-cycle capture strobe
//     busy        - burst in progress
//     finished    - single-cycle end-of-burst pulse
//     timeout_err - sticky abort flag
//     sent_cnt    - words acknowledged in the current/last burst
//   Modports: master = issuer side, slave = requester/downstream side.
interface buffer_issuer_if
    import matrix_mul_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic               start;
    logic [DEPTH*N-1:0] load_data;
    logic [CW-1:0]      count;
    logic               done_in;
    logic [N-1:0]       d_out;
    logic               do_strobe;
    logic               busy;
    logic               finished;
    logic               timeout_err;
    logic [CW-1:0]      sent_cnt;

    modport master (
        input  start, load_data, count, done_in,
        output d_out, do_strobe, busy, finished, timeout_err, sent_cnt
    );

    modport slave (
        output start, load_data, count, done_in,
        input  d_out, do_strobe, busy, finished, timeout_err, sent_cnt
    );

endinterface

// File: rtl/buffer_issuer.sv
// buffer_issuer
//   Captures a block of up to DEPTH words on start and issues them one at a
//   time to a downstream capture buffer, pulsing do_strobe with the word on
//   d_out and waiting for done_in before moving to the next word. A word that
//   is not acknowledged within TIMEOUT cycles of its strobe aborts the burst.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-low reset
//     bus   - buffer_issuer_if.master (request, handshake and status signals)
//   All outputs are registered so d_out and do_strobe change together.
module buffer_issuer
    import matrix_mul_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            reset,
    buffer_issuer_if.master bus
);

    localparam int            CW         = $clog2(DEPTH + 1);
    localparam int            TW         = $clog2(TIMEOUT);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
    // The timer starts at 0 in the first WAIT cycle, so the abort decision is
    // taken on the cycle whose increment would bring it to TIMEOUT-1; this puts
    // finished exactly TIMEOUT cycles after the unanswered strobe.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);

    state_t             state, state_d;
    logic [DEPTH*N-1:0] data_q, data_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      sent_q, sent_d;
    logic [CW-1:0]      sent_inc;
    logic [CW-1:0]      count_clamped;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N-1:0]       d_out_q, d_out_d;
    logic               do_q, do_d;
    logic               busy_q, busy_d;
    logic               fin_q, fin_d;
    logic               terr_q, terr_d;

    assign count_clamped = (bus.count > DEPTH_CNT) ? DEPTH_CNT : bus.count;
    assign sent_inc      = sent_q + CW'(1);

    // Next-state logic: done_in is checked before timer expiry so a late
    // acknowledge arriving on the expiry cycle still counts.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (count_clamped == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.done_in) begin
                    state_d = (sent_inc == count_q) ? ST_FINISH : ST_ISSUE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next-values. Outputs are derived from the next
    // state so they are registered alongside it; the word for an upcoming
    // ISSUE is selected with the progress count it will be issued under.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        sent_d  = sent_q;
        timer_d = timer_q;
        terr_d  = terr_q;
        d_out_d = d_out_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    data_d  = bus.load_data;
                    count_d = count_clamped;
                    sent_d  = '0;
                    terr_d  = 1'b0;
                end
            end
            ST_ISSUE: timer_d = '0;
            ST_WAIT: begin
                if (bus.done_in) begin
                    sent_d = sent_inc;
                end else if (timer_q == TIMER_LAST) begin
                    terr_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: ;
        endcase
        if (state_d == ST_ISSUE) begin
            d_out_d = data_d[int'(sent_d)*N +: N];
        end
        do_d   = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
        fin_d  = (state_d == ST_FINISH);
    end

    // State and register bank; reset clears everything immediately so a
    // burst interrupted by reset produces no partial finished pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            data_q  <= '0;
            count_q <= '0;
            sent_q  <= '0;
            timer_q <= '0;
            terr_q  <= 1'b0;
            d_out_q <= '0;
            do_q    <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state   <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            sent_q  <= sent_d;
            timer_q <= timer_d;
            terr_q  <= terr_d;
            d_out_q <= d_out_d;
            do_q    <= do_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
        end
    end

    assign bus.d_out       = d_out_q;
    assign bus.do_strobe   = do_q;
    assign bus.busy        = busy_q;
    assign bus.finished    = fin_q;
    assign bus.timeout_err = terr_q;
    assign bus.sent_cnt    = sent_q;

endmodule

// File: tb/tb_buffer_issuer.sv
// tb_buffer_issuer
//   Scoreboard bench for buffer_issuer. The stimulus process computes, for
//   each burst, which words must be strobed in which cycle and how the burst
//   ends, from the ack delays it chooses for the downstream buffer. A
//   responder process models the downstream buffer and a monitor process
//   compares every strobe and end-of-burst pulse against the queued results.
module tb_buffer_issuer;
    import matrix_mul_pkg::*;

    localparam int N       = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int NEVER   = TIMEOUT;

    typedef struct {
        logic [N-1:0] word;
        int           cyc;
    } exp_do_t;

    typedef struct {
        int cyc;
        int sent;
        bit terr;
    } exp_res_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    exp_do_t  expDo[$];
    exp_res_t expRes[$];
    int       ackQ[$];

    int compared    = 0;
    int mismatched  = 0;
    int burstsDone  = 0;
    int burstTarget = 0;
    int lastSent    = 0;
    bit lastTerr    = 1'b0;
    int spurCyc     = -1;

    buffer_issuer_if #(.N(N), .DEPTH(DEPTH)) bus ();

    buffer_issuer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [DEPTH*N-1:0] pack4(input logic [N-1:0] w0, input logic [N-1:0] w1,
                                                  input logic [N-1:0] w2, input logic [N-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Downstream buffer: acknowledges each strobe after the planned delay,
    // plus any single spurious ack the stimulus asks for.
    initial begin
        int ackAt;
        int d;
        ackAt       = -1;
        bus.done_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ackAt       = -1;
                bus.done_in = 1'b0;
            end else begin
                bus.done_in = (cyc == ackAt) || (cyc == spurCyc);
                if (bus.do_strobe) begin
                    d = (ackQ.size() > 0) ? ackQ.pop_front() : NEVER;
                    if (d < TIMEOUT) ackAt = cyc + d;
                end
            end
        end
    end

    // Monitor: compares strobes, held words and end-of-burst status.
    initial begin
        logic [N-1:0] lastWord;
        exp_do_t      e;
        exp_res_t     r;
        lastWord = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.do_strobe) begin
                    if (expDo.size() == 0) begin
                        checkOutput("do_unexpected", 64'(bus.do_strobe), 64'(0));
                    end else begin
                        e = expDo.pop_front();
                        checkOutput("do_word", 64'(bus.d_out), 64'(e.word));
                        checkOutput("do_cycle", 64'(cyc), 64'(e.cyc));
                        lastWord = e.word;
                    end
                end else if (bus.busy && !bus.finished) begin
                    checkOutput("hold_word", 64'(bus.d_out), 64'(lastWord));
                end
                if (bus.finished) begin
                    if (expRes.size() == 0) begin
                        checkOutput("finished_unexpected", 64'(bus.finished), 64'(0));
                    end else begin
                        r = expRes.pop_front();
                        checkOutput("finish_cycle", 64'(cyc), 64'(r.cyc));
                        checkOutput("sent_cnt", 64'(bus.sent_cnt), 64'(r.sent));
                        checkOutput("timeout_err", 64'(bus.timeout_err), 64'(r.terr));
                        checkOutput("busy_in_finish", 64'(bus.busy), 64'(1));
                    end
                    burstsDone++;
                end
            end
        end
    end

    // Issues one burst and queues its expected outcome: word i is strobed
    // one cycle after the previous word's ack (or after start), and the
    // burst ends one cycle after the last ack or TIMEOUT cycles after an
    // unanswered strobe.
    task automatic applyStimulus(input int cnt, input logic [DEPTH*N-1:0] data,
                                 input int delays[DEPTH], input bit midStart);
        int       k;
        int       fin;
        int       sent;
        int       c0;
        bit       terr;
        exp_do_t  e;
        exp_res_t r;
        @(negedge clk);
        c0            = cyc;
        burstTarget   = burstsDone + 1;
        bus.start     = 1'b1;
        bus.load_data = data;
        bus.count     = CW'(cnt);
        k    = (cnt > DEPTH) ? DEPTH : cnt;
        fin  = 1;
        sent = 0;
        terr = 1'b0;
        for (int i = 0; i < k; i++) begin
            e.word = data[i*N +: N];
            e.cyc  = c0 + fin;
            expDo.push_back(e);
            ackQ.push_back(delays[i]);
            if (delays[i] < TIMEOUT) begin
                sent++;
                fin += delays[i] + 1;
            end else begin
                terr = 1'b1;
                fin += TIMEOUT;
                break;
            end
        end
        r.cyc  = c0 + fin;
        r.sent = sent;
        r.terr = terr;
        expRes.push_back(r);
        lastSent = sent;
        lastTerr = terr;
        @(negedge clk);
        bus.start = midStart && (k > 0);
        for (int i = 0; i < DEPTH; i++) bus.load_data[i*N +: N] = $urandom();
        bus.count = CW'($urandom_range(1, 7));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitBurst();
        for (int i = 0; i < 300 && burstsDone < burstTarget; i++) @(negedge clk);
        checkOutput("burst_completed", 64'(burstsDone >= burstTarget), 64'(1));
        if (burstsDone < burstTarget) begin
            expDo.delete();
            expRes.delete();
            ackQ.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [DEPTH*N-1:0] data;
        int                 dl[DEPTH];
        int                 cnt;

        bus.start     = 1'b0;
        bus.load_data = '0;
        bus.count     = '0;

        // Reset state
        #3;
        checkOutput("rst_d_out", 64'(bus.d_out), 64'(0));
        checkOutput("rst_do", 64'(bus.do_strobe), 64'(0));
        checkOutput("rst_busy", 64'(bus.busy), 64'(0));
        checkOutput("rst_finished", 64'(bus.finished), 64'(0));
        checkOutput("rst_timeout_err", 64'(bus.timeout_err), 64'(0));
        checkOutput("rst_sent_cnt", 64'(bus.sent_cnt), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Normal burst of three words
        applyStimulus(3, pack4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444), '{1, 1, 1, 1}, 1'b0);
        waitBurst();

        // Empty burst and clamped burst
        applyStimulus(0, pack4(32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'hD0D0D0D0), '{1, 1, 1, 1}, 1'b0);
        waitBurst();
        applyStimulus(7, pack4(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10), '{1, 1, 1, 1}, 1'b0);
        waitBurst();

        // Timeout on the second word, flag sticky, then cleared by next start
        applyStimulus(3, pack4(32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004), '{1, NEVER, 1, 1}, 1'b0);
        waitBurst();
        checkOutput("timeout_sticky", 64'(bus.timeout_err), 64'(lastTerr));
        applyStimulus(2, pack4(32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004), '{5, 5, 1, 1}, 1'b0);
        waitBurst();

        // Spurious ack in IDLE
        @(negedge clk);
        spurCyc = cyc + 1;
        repeat (3) @(negedge clk);
        checkOutput("spurious_sent_cnt", 64'(bus.sent_cnt), 64'(lastSent));
        checkOutput("spurious_busy", 64'(bus.busy), 64'(0));

        // Ack on the expiry cycle, and start while busy
        applyStimulus(2, pack4(32'h77770001, 32'h77770002, 32'h77770003, 32'h77770004), '{7, 7, 1, 1}, 1'b0);
        waitBurst();
        applyStimulus(3, pack4(32'h55550001, 32'h55550002, 32'h55550003, 32'h55550004), '{3, 2, 3, 1}, 1'b1);
        waitBurst();

        // Reset asserted in WAIT with no clock edge before the check
        applyStimulus(3, pack4(32'h99990001, 32'h99990002, 32'h99990003, 32'h99990004), '{NEVER, 1, 1, 1}, 1'b0);
        @(negedge clk);
        checkOutput("pre_reset_busy", 64'(bus.busy), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_d_out", 64'(bus.d_out), 64'(0));
        checkOutput("midrst_do", 64'(bus.do_strobe), 64'(0));
        checkOutput("midrst_busy", 64'(bus.busy), 64'(0));
        checkOutput("midrst_finished", 64'(bus.finished), 64'(0));
        checkOutput("midrst_timeout_err", 64'(bus.timeout_err), 64'(0));
        checkOutput("midrst_sent_cnt", 64'(bus.sent_cnt), 64'(0));
        expDo.delete();
        expRes.delete();
        ackQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        applyStimulus(2, pack4(32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D, 32'hFEEDFACE), '{1, 1, 1, 1}, 1'b0);
        waitBurst();

        // Randomized bursts
        for (int t = 0; t < 30; t++) begin
            cnt = $urandom_range(0, 7);
            for (int i = 0; i < DEPTH; i++) begin
                data[i*N +: N] = $urandom();
                dl[i] = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 7));
            end
            applyStimulus(cnt, data, dl, 1'($urandom_range(0, 1)));
            waitBurst();
            if ($urandom_range(0, 3) == 0) begin
                spurCyc = cyc + 1;
                repeat (3) @(negedge clk);
                checkOutput("rand_spurious_sent_cnt", 64'(bus.sent_cnt), 64'(lastSent));
            end
        end

        repeat (3) @(negedge clk);
        checkOutput("queues_drained", 64'(expDo.size() + expRes.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        mismatched++;
        $display("[TB] FAIL watchdog: actual=no completion required=completion before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
